// File: rtl/od_bus_receiver.sv
// od_bus_receiver
//
// Receives six wired-OR open-drain lines, synchronizes and debounces each
// one, and presents debounced falling edges as events under a valid/ack
// handshake. Falls that arrive while an event is still waiting are
// collected in a shadow register and presented after the ack. A fall on a
// line that is already waiting in the shadow sets a sticky overrun flag.
//
// Parameters
//   DEBOUNCE     consecutive stable synced cycles needed to accept a change (1..15)
//   SYNC_STAGES  synchronizer depth (2..3)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-low reset
//   y[5:0]     open-drain lines; anything other than a hard 0 reads as 1
//   evt_ack    consumer accepts the presented event
//   level[5:0] debounced line levels
//   evt_valid  an event is presented
//   evt_mask   lines that fell in the presented event
//   overrun    sticky, a falling edge was lost
//   glitch_cnt saturating count of cycles in which some line abandoned a
//              partial debounce count (only with OD_RX_GLITCH_COUNT_EN)
//
// Optional feature macro: OD_RX_GLITCH_COUNT_EN

module od_bus_receiver #(
  parameter int DEBOUNCE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] y,
  input  logic       evt_ack,
  output logic [5:0] level,
  output logic       evt_valid,
  output logic [5:0] evt_mask,
  output logic       overrun
`ifdef OD_RX_GLITCH_COUNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  // A change is accepted on the edge where the count would reach DEBOUNCE,
  // i.e. when the count already stands at DEBOUNCE-1 and the line still differs.
  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [5:0] y_res;
  logic [5:0] synced;
  logic [5:0] settle;
  logic [5:0] fall;
  logic [5:0] level_q;
`ifdef OD_RX_GLITCH_COUNT_EN
  logic [5:0] glitch_line;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] sync_reg;
      logic [3:0]             cnt_reg;
      logic                   lvl_reg;
      logic                   differ;

      // Pulled-up line: only a driven 0 counts as low.
      assign y_res[gi] = (y[gi] === 1'b0) ? 1'b0 : 1'b1;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync_reg <= '1;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], y_res[gi]};
        end
      end

      assign synced[gi] = sync_reg[SYNC_STAGES-1];
      assign differ     = (synced[gi] != lvl_reg);
      assign settle[gi] = differ && (cnt_reg == CNT_LAST);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= 4'd0;
          lvl_reg <= 1'b1;
        end else if (!differ || settle[gi]) begin
          cnt_reg <= 4'd0;
          if (settle[gi]) begin
            lvl_reg <= synced[gi];
          end
        end else begin
          cnt_reg <= cnt_reg + 4'd1;
        end
      end

      assign level_q[gi] = lvl_reg;
      // A settling 1 can only go to 0, so settle on a high line is a fall.
      assign fall[gi]    = settle[gi] & lvl_reg;
`ifdef OD_RX_GLITCH_COUNT_EN
      assign glitch_line[gi] = !differ && (cnt_reg != 4'd0);
`endif
    end
  endgenerate

  assign level = level_q;

  // Event handshake FSM
  state_t     state_reg, state_next;
  logic [5:0] mask_reg, mask_next;
  logic [5:0] shadow_reg, shadow_next;
  logic       valid_reg, valid_next;
  logic       ovr_reg, ovr_next;
  logic [5:0] merged;

  assign merged = shadow_reg | fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      mask_reg   <= 6'h00;
      shadow_reg <= 6'h00;
      valid_reg  <= 1'b0;
      ovr_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mask_reg   <= mask_next;
      shadow_reg <= shadow_next;
      valid_reg  <= valid_next;
      ovr_reg    <= ovr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mask_next   = mask_reg;
    shadow_next = shadow_reg;
    valid_next  = valid_reg;
    ovr_next    = ovr_reg;
    case (state_reg)
      IDLE: begin
        if (|fall) begin
          mask_next  = fall;
          valid_next = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        // Two falls of one line collapse into one mask bit: one is lost.
        if (|(shadow_reg & fall)) begin
          ovr_next = 1'b1;
        end
        if (evt_ack) begin
          if (|merged) begin
            mask_next   = merged;
            shadow_next = 6'h00;
          end else begin
            mask_next  = 6'h00;
            valid_next = 1'b0;
            state_next = IDLE;
          end
        end else begin
          shadow_next = merged;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign evt_valid = valid_reg;
  assign evt_mask  = mask_reg;
  assign overrun   = ovr_reg;

`ifdef OD_RX_GLITCH_COUNT_EN
  logic [7:0] glitch_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_reg <= 8'd0;
    end else if ((|glitch_line) && (glitch_reg != 8'hFF)) begin
      glitch_reg <= glitch_reg + 8'd1;
    end
  end

  assign glitch_cnt = glitch_reg;
`endif

endmodule

// File: tb/tb_od_bus_receiver.sv
// tb_od_bus_receiver
//
// Drives od_bus_receiver through directed scenarios and a randomized run,
// comparing every cycle against a behavioural model: a line's level flips
// once its last DEBOUNCE synced samples all disagree with it, and events
// are tracked as pending/collected sets of fallen lines.

module tb_od_bus_receiver;

  localparam int DEBOUNCE    = 4;
  localparam int SYNC_STAGES = 2;

  logic       clk;
  logic       rst;
  logic [5:0] y;
  logic       evt_ack;
  logic [5:0] level;
  logic       evt_valid;
  logic [5:0] evt_mask;
  logic       overrun;
`ifdef OD_RX_GLITCH_COUNT_EN
  logic [7:0] glitch_cnt;
`endif

  od_bus_receiver #(
    .DEBOUNCE   (DEBOUNCE),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .y        (y),
    .evt_ack  (evt_ack),
    .level    (level),
    .evt_valid(evt_valid),
    .evt_mask (evt_mask),
    .overrun  (overrun)
`ifdef OD_RX_GLITCH_COUNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [5:0] m_pipe [SYNC_STAGES];
  logic [5:0] m_hist [DEBOUNCE];
  logic [5:0] m_lvl;
  logic [5:0] m_run;
  logic [5:0] m_mask;
  logic [5:0] m_shadow;
  logic       m_valid;
  logic       m_ovr;
  int         m_gc;

  task automatic model_reset();
    for (int k = 0; k < SYNC_STAGES; k++) m_pipe[k] = 6'h3F;
    for (int k = 0; k < DEBOUNCE; k++) m_hist[k] = 6'h3F;
    m_lvl    = 6'h3F;
    m_run    = 6'h00;
    m_mask   = 6'h00;
    m_shadow = 6'h00;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_gc     = 0;
  endtask

  task automatic model_edge(input logic [5:0] yv, input logic ackv);
    logic [5:0] s, r, flip, fall;
    for (int i = 0; i < 6; i++) r[i] = (yv[i] === 1'b0) ? 1'b0 : 1'b1;
    s = m_pipe[SYNC_STAGES-1];
    for (int k = SYNC_STAGES - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = r;
    for (int k = DEBOUNCE - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
    flip = 6'h3F;
    for (int k = 0; k < DEBOUNCE; k++) flip = flip & (m_hist[k] ^ m_lvl);
    // a partial run of disagreement abandoned this cycle
    if ((|(~(s ^ m_lvl) & m_run)) && m_gc < 255) m_gc++;
    m_run = (s ^ m_lvl) & ~flip;
    fall  = flip & m_lvl;
    m_lvl = m_lvl ^ flip;
    if (!m_valid) begin
      if (fall != 6'h00) begin
        m_mask  = fall;
        m_valid = 1'b1;
      end
    end else begin
      if ((m_shadow & fall) != 6'h00) m_ovr = 1'b1;
      if (ackv) begin
        if ((m_shadow | fall) != 6'h00) begin
          m_mask   = m_shadow | fall;
          m_shadow = 6'h00;
        end else begin
          m_mask  = 6'h00;
          m_valid = 1'b0;
        end
      end else begin
        m_shadow = m_shadow | fall;
      end
    end
  endtask

  task automatic step(input logic [5:0] yv, input logic ackv);
    @(negedge clk);
    y       = yv;
    evt_ack = ackv;
    @(posedge clk);
    model_edge(yv, ackv);
    #1;
    n_cmp++;
    if (level !== m_lvl) begin
      n_err++;
      $display("FAIL level: got %h want %h at %0t", level, m_lvl, $time);
    end
    n_cmp++;
    if (evt_valid !== m_valid) begin
      n_err++;
      $display("FAIL evt_valid: got %b want %b at %0t", evt_valid, m_valid, $time);
    end
    n_cmp++;
    if (evt_mask !== m_mask) begin
      n_err++;
      $display("FAIL evt_mask: got %h want %h at %0t", evt_mask, m_mask, $time);
    end
    n_cmp++;
    if (overrun !== m_ovr) begin
      n_err++;
      $display("FAIL overrun: got %b want %b at %0t", overrun, m_ovr, $time);
    end
`ifdef OD_RX_GLITCH_COUNT_EN
    n_cmp++;
    if (glitch_cnt !== 8'(m_gc)) begin
      n_err++;
      $display("FAIL glitch_cnt: got %0d want %0d at %0t", glitch_cnt, m_gc, $time);
    end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    y       = 6'h3F;
    evt_ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int n = 0; n < 6; n++) begin
      step(6'h3F, 1'b0);
      n_cmp++;
      if (level !== 6'h3F || evt_valid !== 1'b0 || overrun !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle: level=%h valid=%b ovr=%b want 3f 0 0", level, evt_valid, overrun);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_debounce_latency();
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      step(6'h3E, 1'b0);
      n_cmp++;
      if (level[0] !== ((n >= 6) ? 1'b0 : 1'b1)) begin
        n_err++;
        $display("FAIL latency: edge %0d level[0]=%b want %b", n, level[0], (n >= 6) ? 1'b0 : 1'b1);
      end
    end
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_mask !== 6'h01) begin
      n_err++;
      $display("FAIL first_event: valid=%b mask=%h want 1 01", evt_valid, evt_mask);
    end
    step(6'h3E, 1'b1);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ack_clear: valid=%b want 0", evt_valid);
    end
    for (int n = 0; n < 10; n++) begin
      step(6'h3F, 1'b0);
      n_cmp++;
      if (evt_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rise_no_event: valid=%b want 0", evt_valid);
      end
    end
    $display("test_debounce_latency done");
  endtask

  task automatic test_glitch_reject();
    do_reset();
    for (int n = 0; n < 3; n++) step(6'h3B, 1'b0);
    for (int n = 0; n < 8; n++) begin
      step(6'h3F, 1'b0); // released, pulled up
      n_cmp++;
      if (level !== 6'h3F || evt_valid !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_reject: level=%h valid=%b want 3f 0", level, evt_valid);
      end
    end
`ifdef OD_RX_GLITCH_COUNT_EN
    n_cmp++;
    if (glitch_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL glitch_one: got %0d want 1", glitch_cnt);
    end
`endif
    $display("test_glitch_reject done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int n = 0; n < 6; n++) step(6'h3D, 1'b0);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_mask !== 6'h02) begin
      n_err++;
      $display("FAIL b2b_first: valid=%b mask=%h want 1 02", evt_valid, evt_mask);
    end
    for (int n = 0; n < 8; n++) begin
      step(6'h35, 1'b0);
      n_cmp++;
      if (evt_valid !== 1'b1 || evt_mask !== 6'h02) begin
        n_err++;
        $display("FAIL b2b_hold: valid=%b mask=%h want 1 02", evt_valid, evt_mask);
      end
    end
    step(6'h35, 1'b1);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_mask !== 6'h08) begin
      n_err++;
      $display("FAIL b2b_second: valid=%b mask=%h want 1 08", evt_valid, evt_mask);
    end
    step(6'h35, 1'b1);
    n_cmp++;
    if (evt_valid !== 1'b0 || evt_mask !== 6'h00) begin
      n_err++;
      $display("FAIL b2b_idle: valid=%b mask=%h want 0 00", evt_valid, evt_mask);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_overrun();
    do_reset();
    for (int n = 0; n < 6; n++) step(6'h2F, 1'b0);
    for (int n = 0; n < 6; n++) step(6'h0F, 1'b0);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_early: got %b want 0", overrun);
    end
    for (int n = 0; n < 6; n++) step(6'h2F, 1'b0);
    for (int n = 0; n < 6; n++) step(6'h0F, 1'b0);
    n_cmp++;
    if (overrun !== 1'b1 || evt_mask !== 6'h10) begin
      n_err++;
      $display("FAIL ovr_set: ovr=%b mask=%h want 1 10", overrun, evt_mask);
    end
    for (int n = 0; n < 12; n++) step(6'h3F, 1'b1);
    n_cmp++;
    if (overrun !== 1'b1 || evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_sticky: ovr=%b valid=%b want 1 0", overrun, evt_valid);
    end
    do_reset();
    step(6'h3F, 1'b0);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_reset: got %b want 0", overrun);
    end
    $display("test_overrun done");
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int n = 0; n < 6; n++) step(6'h3E, 1'b0);
    for (int n = 0; n < 6; n++) step(6'h3C, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (evt_valid !== 1'b0 || level !== 6'h3F || evt_mask !== 6'h00) begin
      n_err++;
      $display("FAIL async_reset: valid=%b level=%h mask=%h want 0 3f 00", evt_valid, level, evt_mask);
    end
    model_reset();
    @(negedge clk);
    y = 6'h3F;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step(6'h3F, 1'b1);
      n_cmp++;
      if (evt_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_discard: valid=%b want 0", evt_valid);
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [5:0] yv;
    logic       ackv;
    int         hold;
    do_reset();
    yv = 6'h3F;
    for (int n = 0; n < 3000; n++) begin
      // alternate bursty short pulses with long stable stretches
      hold = ((n / 200) % 2 == 0) ? 3 : 12;
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(hold - 1, 0) == 0) yv[i] = ~yv[i];
      end
      ackv = ($urandom_range(3, 0) == 0);
      step(yv, ackv);
    end
    $display("test_random done");
  endtask

  initial begin
    rst     = 1'b0;
    y       = 6'h3F;
    evt_ack = 1'b0;
    model_reset();
    test_reset();
    test_debounce_latency();
    test_glitch_reject();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
